genie_code_loader: RTL and testbench

//  Upstream feeder of the Game Genie code table. Parses ASCII Game Genie codes streamed from the
//  OSD/ioctl download path, descrambles 6- or 8-letter codes and emits one 38-bit code word per code,

---
 rtl/genie_code_loader_pkg.sv | 58 +++++
 rtl/genie_code_loader_if.sv | 26 ++
 rtl/genie_letter_decode.sv | 36 +++
 rtl/genie_code_loader.sv | 181 ++++++++++++++++++
 tb/tb_genie_code_loader.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/genie_code_loader_pkg.sv
// Shared definitions for the Game Genie code loader.
// - Code-word field positions: {strobe, index[3:0], enable, cmp_en, addr[14:0], compare, replace}
// - Separator/terminator character constants
// - FSM state encodings
// - letter_to_nibble(): upper-case Game Genie letter -> {valid, nibble}
package genie_code_loader_pkg;

  localparam int unsigned CodeW     = 38;
  localparam int unsigned StrobeBit = 37;
  localparam int unsigned IndexHi   = 36;
  localparam int unsigned IndexLo   = 33;
  localparam int unsigned EnableBit = 32;
  localparam int unsigned CmpEnBit  = 31;
  localparam int unsigned AddrHi    = 30;
  localparam int unsigned AddrLo    = 16;
  localparam int unsigned CompareHi = 15;
  localparam int unsigned CompareLo = 8;
  localparam int unsigned ReplaceHi = 7;
  localparam int unsigned ReplaceLo = 0;

  localparam logic [7:0] ChNul   = 8'h00;
  localparam logic [7:0] ChLf    = 8'h0A;
  localparam logic [7:0] ChCr    = 8'h0D;
  localparam logic [7:0] ChSemi  = 8'h3B;
  localparam logic [7:0] ChDash  = 8'h2D;
  localparam logic [7:0] ChSpace = 8'h20;

  localparam logic [1:0] StCollect = 2'd0;
  localparam logic [1:0] StSkip    = 2'd1;
  localparam logic [1:0] StDecode  = 2'd2;
  localparam logic [1:0] StEmit    = 2'd3;

  // Letter order A P Z L G I T Y E O X U K S V N maps to 0..15. Bit 4 flags a letter.
  function automatic logic [4:0] letter_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    case (c)
      8'h41:   r = 5'h10;  // A
      8'h50:   r = 5'h11;  // P
      8'h5A:   r = 5'h12;  // Z
      8'h4C:   r = 5'h13;  // L
      8'h47:   r = 5'h14;  // G
      8'h49:   r = 5'h15;  // I
      8'h54:   r = 5'h16;  // T
      8'h59:   r = 5'h17;  // Y
      8'h45:   r = 5'h18;  // E
      8'h4F:   r = 5'h19;  // O
      8'h58:   r = 5'h1A;  // X
      8'h55:   r = 5'h1B;  // U
      8'h4B:   r = 5'h1C;  // K
      8'h53:   r = 5'h1D;  // S
      8'h56:   r = 5'h1E;  // V
      8'h4E:   r = 5'h1F;  // N
      default: r = 5'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/genie_code_loader_if.sv
// Character stream and code-table bus of the Game Genie code loader.
// master: download source / table side (drives dl_start and the character stream).
// slave:  the loader (accepts characters, produces code words and status).
interface genie_code_loader_if;
  import genie_code_loader_pkg::*;

  logic             dl_start;
  logic             char_valid;
  logic [7:0]       char_data;
  logic             char_ready;
  logic [CodeW-1:0] code;
  logic [5:0]       code_count;
  logic [5:0]       err_count;
  logic             overflow;

  modport master (
    output dl_start, char_valid, char_data,
    input  char_ready, code, code_count, err_count, overflow
  );

  modport slave (
    input  dl_start, char_valid, char_data,
    output char_ready, code, code_count, err_count, overflow
  );

endinterface

// File: rtl/genie_letter_decode.sv
// Combinational classifier for one ASCII character of a Game Genie code.
// Ports:
//   char_data  in  8  ASCII character
//   is_letter  out 1  character is a Game Genie letter
//   is_sep     out 1  '-' or ' ' (ignored)
//   is_term    out 1  LF, CR, ';' or NUL (ends a code)
//   nibble     out 4  letter value, 0 when not a letter
module genie_letter_decode
  import genie_code_loader_pkg::*;
#(
  parameter bit ALLOW_LOWER = 1'b1
) (
  input  logic [7:0] char_data,
  output logic       is_letter,
  output logic       is_sep,
  output logic       is_term,
  output logic [3:0] nibble
);

  logic [7:0] upper;
  logic [4:0] lv;

  always_comb begin
    upper = char_data;
    if (ALLOW_LOWER && (char_data >= 8'h61) && (char_data <= 8'h7A)) begin
      upper = char_data - 8'h20;
    end
    lv        = letter_to_nibble(upper);
    is_letter = lv[4];
    nibble    = lv[3:0];
    is_sep    = (char_data == ChDash) || (char_data == ChSpace);
    is_term   = (char_data == ChLf) || (char_data == ChCr) ||
                (char_data == ChSemi) || (char_data == ChNul);
  end

endmodule

// File: rtl/genie_code_loader.sv
// Parses ASCII Game Genie codes, descrambles 6/8-letter codes and emits one 38-bit code word
// per valid code with a single-cycle load strobe in bit 37.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   bus      slave modport of genie_code_loader_if:
//            dl_start, char_valid, char_data in; char_ready, code, code_count, err_count,
//            overflow out
module genie_code_loader
  import genie_code_loader_pkg::*;
#(
  parameter int unsigned MAX_CODES   = 32,
  parameter bit          ALLOW_LOWER = 1'b1
) (
  input logic              clk,
  input logic              reset_n,
  genie_code_loader_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       nib_q [8];
  logic [14:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       cmp_q, cmp_d;
  logic             cmp_en_q;
  logic [CodeW-1:0] code_q;
  logic [5:0]       code_count_q;
  logic [5:0]       err_count_q;
  logic             overflow_q;

  logic       is_letter, is_sep, is_term;
  logic [3:0] nibble;
  logic       xfer, err, nib_we, eight;
  logic       in_emit, room, emit_ok, emit_drop;

  genie_letter_decode #(
    .ALLOW_LOWER(ALLOW_LOWER)
  ) u_letter_decode (
    .char_data(bus.char_data),
    .is_letter(is_letter),
    .is_sep   (is_sep),
    .is_term  (is_term),
    .nibble   (nibble)
  );

  assign bus.char_ready = (state_q == StCollect) || (state_q == StSkip);
  // dl_start takes priority over a character offered in the same cycle.
  assign xfer  = bus.char_valid && bus.char_ready && !bus.dl_start;
  assign eight = (cnt_q == 4'd8);

  assign in_emit   = (state_q == StEmit) && !bus.dl_start;
  assign room      = ({26'd0, code_count_q} < MAX_CODES);
  assign emit_ok   = in_emit && room;
  assign emit_drop = in_emit && !room;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err     = 1'b0;
    nib_we  = 1'b0;
    case (state_q)
      StCollect: begin
        if (xfer) begin
          if (is_letter) begin
            if (eight) begin
              err     = 1'b1;
              state_d = StSkip;
            end else begin
              nib_we = 1'b1;
              cnt_d  = cnt_q + 4'd1;
            end
          end else if (is_term) begin
            if ((cnt_q == 4'd6) || eight) begin
              state_d = StDecode;
            end else if (cnt_q != 4'd0) begin
              err   = 1'b1;
              cnt_d = 4'd0;
            end
          end else if (!is_sep) begin
            err     = 1'b1;
            state_d = StSkip;
          end
        end
      end
      StSkip: begin
        if (xfer && is_term) begin
          state_d = StCollect;
          cnt_d   = 4'd0;
        end
      end
      StDecode: state_d = StEmit;
      default: begin
        state_d = StCollect;
        cnt_d   = 4'd0;
      end
    endcase
    if (bus.dl_start) begin
      state_d = StCollect;
      cnt_d   = 4'd0;
      err     = 1'b0;
    end
  end

  // Descramble. Bit 3 of the data byte comes from n7 for 8-letter codes, n5 otherwise.
  always_comb begin
    addr_d = {nib_q[3][2:0], nib_q[4][3], nib_q[5][2:0], nib_q[1][3],
              nib_q[2][2:0], nib_q[3][3], nib_q[4][2:0]};
    data_d = {nib_q[0][3], nib_q[1][2:0], (eight ? nib_q[7][3] : nib_q[5][3]), nib_q[0][2:0]};
    cmp_d  = eight ? {nib_q[6][3], nib_q[7][2:0], nib_q[5][3], nib_q[6][2:0]} : 8'h00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StCollect;
      cnt_q   <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        nib_q[i] <= 4'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (nib_we) begin
        nib_q[cnt_q[2:0]] <= nibble;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= 15'd0;
      data_q   <= 8'd0;
      cmp_q    <= 8'd0;
      cmp_en_q <= 1'b0;
    end else if (state_q == StDecode) begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      cmp_q    <= cmp_d;
      cmp_en_q <= eight;
    end
  end

  // Fields only change together with the strobe, so code[36:0] is stable between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_q <= '0;
    end else if (emit_ok) begin
      code_q <= {1'b1, code_count_q[3:0], 1'b1, cmp_en_q, addr_q, cmp_q, data_q};
    end else begin
      code_q[StrobeBit] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_count_q <= 6'd0;
      err_count_q  <= 6'd0;
      overflow_q   <= 1'b0;
    end else if (bus.dl_start) begin
      code_count_q <= 6'd0;
      err_count_q  <= 6'd0;
      overflow_q   <= 1'b0;
    end else begin
      if (emit_ok) begin
        code_count_q <= code_count_q + 6'd1;
      end
      if (emit_drop) begin
        overflow_q <= 1'b1;
      end
      if (err && (err_count_q != 6'd63)) begin
        err_count_q <= err_count_q + 6'd1;
      end
    end
  end

  assign bus.code       = code_q;
  assign bus.code_count = code_count_q;
  assign bus.err_count  = err_count_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_genie_code_loader.sv
// Directed bench for genie_code_loader: a table of single-code vectors followed by
// hand-written multi-cycle sequences (streaming, error mix, overflow, abort, saturation).
module tb_genie_code_loader;
  import genie_code_loader_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  genie_code_loader_if bus ();

  genie_code_loader #(
    .MAX_CODES  (32),
    .ALLOW_LOWER(1'b1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [CodeW-1:0] seen [$];
  logic prev_strobe = 1'b0;

  typedef struct packed {
    logic [1:0]  strobes;
    logic [14:0] addr;
    logic [7:0]  data;
    logic [7:0]  cmp;
    logic        cmp_en;
    logic [5:0]  count;
    logic [5:0]  err;
  } exp_t;

  localparam int NV = 12;
  string vec_txt [NV];
  exp_t  vec_exp [NV];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_code(input string name, input logic [CodeW-1:0] c, input int unsigned idx,
                            input int unsigned addr, input int unsigned data,
                            input int unsigned cmp, input int unsigned cmp_en);
    check({name, "_index"},   32'(c[IndexHi:IndexLo]), idx);
    check({name, "_enable"},  32'(c[EnableBit]), 1);
    check({name, "_cmp_en"},  32'(c[CmpEnBit]), cmp_en);
    check({name, "_addr"},    32'(c[AddrHi:AddrLo]), addr);
    check({name, "_compare"}, 32'(c[CompareHi:CompareLo]), cmp);
    check({name, "_data"},    32'(c[ReplaceHi:ReplaceLo]), data);
  endtask

  // Strobe must never be high on two consecutive cycles.
  always @(negedge clk) begin
    if (bus.code[StrobeBit]) begin
      seen.push_back(bus.code);
      check("strobe_single_cycle", 32'(prev_strobe), 0);
    end
    prev_strobe <= bus.code[StrobeBit];
  end

  // Called at a negedge; returns at the negedge after the character was transferred.
  task automatic send_char(input logic [7:0] c, output int waits);
    waits = 0;
    bus.char_valid = 1'b1;
    bus.char_data  = c;
    while (!bus.char_ready && waits < 16) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.char_ready) begin
      checks++;
      errors++;
      $display("FAIL char_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    int w;
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i], w);
    end
    bus.char_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_dl_start();
    bus.char_valid = 1'b0;
    bus.dl_start   = 1'b1;
    @(negedge clk);
    bus.dl_start   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string s;
    int w;

    vec_txt[0]  = "SXIOPO\n";      vec_exp[0]  = '{1, 15'h11D9, 8'hAD, 8'h00, 0, 1, 0};
    vec_txt[1]  = "GOSSIPPE\n";    vec_exp[1]  = '{1, 15'h51DD, 8'h1C, 8'h01, 1, 1, 0};
    vec_txt[2]  = "sxiopo\n";      vec_exp[2]  = '{1, 15'h11D9, 8'hAD, 8'h00, 0, 1, 0};
    vec_txt[3]  = "APZLGITY\n";    vec_exp[3]  = '{1, 15'h3524, 8'h10, 8'h76, 1, 1, 0};
    vec_txt[4]  = "EOXUKSVN\n";    vec_exp[4]  = '{1, 15'h3DAC, 8'h98, 8'hFE, 1, 1, 0};
    vec_txt[5]  = " \r\n SXIOPO;"; vec_exp[5]  = '{1, 15'h11D9, 8'hAD, 8'h00, 0, 1, 0};
    vec_txt[6]  = "GOSS-IPPE\r";   vec_exp[6]  = '{1, 15'h51DD, 8'h1C, 8'h01, 1, 1, 0};
    vec_txt[7]  = "SXIOP\n";       vec_exp[7]  = '{0, 15'h0, 8'h00, 8'h00, 0, 0, 1};
    vec_txt[8]  = "SXIOPOA\n";     vec_exp[8]  = '{0, 15'h0, 8'h00, 8'h00, 0, 0, 1};
    vec_txt[9]  = "SXIOPOAAA\n";   vec_exp[9]  = '{0, 15'h0, 8'h00, 8'h00, 0, 0, 1};
    vec_txt[10] = "SX1OPO\n";      vec_exp[10] = '{0, 15'h0, 8'h00, 8'h00, 0, 0, 1};
    vec_txt[11] = "GO?SSIPPE\n";   vec_exp[11] = '{0, 15'h0, 8'h00, 8'h00, 0, 0, 1};

    bus.dl_start   = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("reset_char_ready", 32'(bus.char_ready), 1);
    check("reset_code_lo", bus.code[31:0], 0);
    check("reset_code_hi", 32'(bus.code[37:32]), 0);
    check("reset_code_count", 32'(bus.code_count), 0);
    check("reset_err_count", 32'(bus.err_count), 0);
    check("reset_overflow", 32'(bus.overflow), 0);

    for (int v = 0; v < NV; v++) begin
      pulse_dl_start();
      seen.delete();
      send_str(vec_txt[v]);
      check($sformatf("v%0d_strobes", v), seen.size(), 32'(vec_exp[v].strobes));
      if (seen.size() > 0) begin
        check_code($sformatf("v%0d", v), seen[0], 0, 32'(vec_exp[v].addr),
                   32'(vec_exp[v].data), 32'(vec_exp[v].cmp), 32'(vec_exp[v].cmp_en));
      end
      check($sformatf("v%0d_code_count", v), 32'(bus.code_count), 32'(vec_exp[v].count));
      check($sformatf("v%0d_err_count", v), 32'(bus.err_count), 32'(vec_exp[v].err));
    end

    // Streamed with char_valid held high; ready gaps of two cycles after each terminator.
    pulse_dl_start();
    seen.delete();
    s = "SXI-OPO;GOSSIPPE\n";
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i], w);
      if (i == 8) check("stream_ready_gap_after_semi", w, 2);
    end
    bus.char_valid = 1'b0;
    check("stream_ready_low_1", 32'(bus.char_ready), 0);
    @(negedge clk);
    check("stream_ready_low_2", 32'(bus.char_ready), 0);
    @(negedge clk);
    check("stream_ready_back", 32'(bus.char_ready), 1);
    repeat (2) @(negedge clk);
    check("stream_strobes", seen.size(), 2);
    if (seen.size() == 2) begin
      check_code("stream_c0", seen[0], 0, 32'h11D9, 32'hAD, 0, 0);
      check_code("stream_c1", seen[1], 1, 32'h51DD, 32'h1C, 32'h01, 1);
    end
    check("stream_code_count", 32'(bus.code_count), 2);

    // Mixed malformed codes without dl_start in between.
    pulse_dl_start();
    seen.delete();
    send_str("SXIOP\n");
    send_str("SXIOPOA\n");
    send_str("SXIOPOAAA\n");
    send_str("SX1OPO\n");
    send_str("SXIOPO\n");
    check("errmix_err_count", 32'(bus.err_count), 4);
    check("errmix_strobes", seen.size(), 1);
    check("errmix_code_count", 32'(bus.code_count), 1);
    if (seen.size() > 0) check_code("errmix", seen[0], 0, 32'h11D9, 32'hAD, 0, 0);

    // NUL terminator.
    pulse_dl_start();
    seen.delete();
    s = "SXIOPO";
    for (int i = 0; i < s.len(); i++) send_char(s[i], w);
    send_char(8'h00, w);
    bus.char_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("nul_strobes", seen.size(), 1);

    // Overflow: 33 codes against 32 slots.
    pulse_dl_start();
    seen.delete();
    repeat (33) send_str("SXIOPO\n");
    check("ovf_strobes", seen.size(), 32);
    for (int i = 0; i < seen.size(); i++) begin
      check($sformatf("ovf_index_%0d", i), 32'(seen[i][IndexHi:IndexLo]), i % 16);
    end
    check("ovf_overflow", 32'(bus.overflow), 1);
    check("ovf_code_count", 32'(bus.code_count), 32);
    pulse_dl_start();
    check("ovf_clr_code_count", 32'(bus.code_count), 0);
    check("ovf_clr_overflow", 32'(bus.overflow), 0);

    // err_count saturates at 63.
    pulse_dl_start();
    seen.delete();
    repeat (64) send_str("1\n");
    check("sat_err_count", 32'(bus.err_count), 63);
    check("sat_strobes", seen.size(), 0);

    // dl_start wins over a simultaneous char: 'S' is dropped, leaving a 5-letter code.
    pulse_dl_start();
    seen.delete();
    bus.dl_start   = 1'b1;
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h53;
    @(negedge clk);
    bus.dl_start = 1'b0;
    send_str("XIOPO\n");
    check("dlwin_strobes", seen.size(), 0);
    check("dlwin_err_count", 32'(bus.err_count), 1);

    // dl_start mid-code discards the partial code.
    pulse_dl_start();
    send_str("SXIOPO\n");
    seen.delete();
    s = "SXI";
    for (int i = 0; i < s.len(); i++) send_char(s[i], w);
    pulse_dl_start();
    send_str("SXIOPO\n");
    check("dlabort_strobes", seen.size(), 1);
    if (seen.size() > 0) check_code("dlabort", seen[0], 0, 32'h11D9, 32'hAD, 0, 0);
    check("dlabort_err_count", 32'(bus.err_count), 0);

    // Async reset mid-code discards the partial code and clears the counts.
    seen.delete();
    s = "SXI";
    for (int i = 0; i < s.len(); i++) send_char(s[i], w);
    bus.char_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_code_count", 32'(bus.code_count), 0);
    check("rst_code_lo", bus.code[31:0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_str("SXIOPO\n");
    check("rstabort_strobes", seen.size(), 1);
    if (seen.size() > 0) check_code("rstabort", seen[0], 0, 32'h11D9, 32'hAD, 0, 0);
    check("rstabort_code_count", 32'(bus.code_count), 1);
    check("rstabort_err_count", 32'(bus.err_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
